fifo_wr_packer: RTL

- Write-side ingress stage in the w_clk domain, directly upstream of the async FIFO write port.
- Accepts a wide valid/ready stream (RATIO lanes of OUT_W bits) and serializes it, lane 0 first, into single-word FIFO writes gated by the FIFO full flag.
- Supports short final beats (partial lanes on s_last).
- Keeps saturating word/packet counters and a sticky lane-count error for status readout.

---
 rtl/fifo_wr_packer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/fifo_wr_packer.sv
// Write-side packer: serializes RATIO-lane input beats, lane 0 first, into single-word
// FIFO writes gated by the FIFO full flag, with saturating status counters.
module fifo_wr_packer #(
  parameter int OUT_W = 8,
  parameter int RATIO = 4,
  parameter int CNT_W = 16,
  localparam int IN_W = OUT_W * RATIO,
  localparam int LW   = $clog2(RATIO) + 1
) (
  input  logic             w_clk,
  input  logic             rst_w_n,
  input  logic             enable,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_last,
  input  logic [LW-1:0]    s_nlanes,
  input  logic             full,
  output logic             w_en,
  output logic [OUT_W-1:0] w_data,
  output logic             busy,
  output logic [CNT_W-1:0] words_written,
  output logic [CNT_W-1:0] pkts_written,
  output logic             err_lanes
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state_reg, state_next;
  logic [IN_W-1:0]    hold_data_reg;
  logic               hold_last_reg;
  logic [LW-1:0]      nl_reg;
  logic [LW-1:0]      idx_reg;
  logic [CNT_W-1:0]   words_reg;
  logic [CNT_W-1:0]   pkts_reg;
  logic               err_reg;

  logic               accept;
  logic               last_lane;
  logic               nl_legal;
  logic [LW-1:0]      nl_load;
  logic [OUT_W-1:0]   lanes [RATIO];

  genvar gi;
  generate
    for (gi = 0; gi < RATIO; gi++) begin : g_lane
      assign lanes[gi] = hold_data_reg[gi*OUT_W +: OUT_W];
    end
  endgenerate

  assign accept    = s_valid && s_ready;
  assign last_lane = (idx_reg == nl_reg - LW'(1));
  assign nl_legal  = (s_nlanes != '0) && (s_nlanes <= LW'(RATIO));
  // Non-last beats, and last beats with a bad lane count, carry all lanes.
  assign nl_load   = (s_last && nl_legal) ? s_nlanes : LW'(RATIO);

  always_ff @(posedge w_clk or negedge rst_w_n) begin
    if (!rst_w_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (accept) state_next = EMIT;
      EMIT: if (w_en && last_lane && !accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    s_ready = 1'b0;
    w_en    = 1'b0;
    case (state_reg)
      IDLE: s_ready = enable;
      EMIT: begin
        w_en    = !full;
        // Next beat may only load as the final lane leaves, so there is no bubble.
        s_ready = enable && !full && last_lane;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_data = '0;
    for (int k = 0; k < RATIO; k++) begin
      if (idx_reg == LW'(k)) w_data = lanes[k];
    end
  end

  always_ff @(posedge w_clk or negedge rst_w_n) begin
    if (!rst_w_n) begin
      hold_data_reg <= '0;
      hold_last_reg <= 1'b0;
      nl_reg        <= '0;
      idx_reg       <= '0;
      words_reg     <= '0;
      pkts_reg      <= '0;
      err_reg       <= 1'b0;
    end else begin
      if (accept) begin
        hold_data_reg <= s_data;
        hold_last_reg <= s_last;
        nl_reg        <= nl_load;
        idx_reg       <= '0;
        if (s_last && !nl_legal) err_reg <= 1'b1;
      end else if (w_en && !last_lane) begin
        idx_reg <= idx_reg + LW'(1);
      end
      if (w_en && (words_reg != '1)) words_reg <= words_reg + CNT_W'(1);
      if (w_en && last_lane && hold_last_reg && (pkts_reg != '1))
        pkts_reg <= pkts_reg + CNT_W'(1);
    end
  end

  assign busy          = (state_reg == EMIT);
  assign words_written = words_reg;
  assign pkts_written  = pkts_reg;
  assign err_lanes     = err_reg;

endmodule
